// File: rtl/mtx_hop_pkg.sv
// Shared definitions for the frequency-hop scheduler: state encoding and
// the hop-index to phase-increment mapping.
package mtx_hop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_GUARD     = 2'd2,
    ST_DWELL     = 2'd3
  } sched_state_t;

  // Full 32-bit result; the caller keeps the low PHASE_WIDTH bits (modulo wrap).
  function automatic logic [31:0] mtx_hop_ph_inc(input logic [31:0] start_inc,
                                                 input logic [31:0] step,
                                                 input logic [31:0] idx);
    return start_inc + idx * step;
  endfunction

endpackage

// File: rtl/mtx_cycle_cnt.sv
// Load-and-count-down counter; tc is high while the count sits at zero.
module mtx_cycle_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mtx_hop_scheduler.sv
// Frame-synchronous frequency-hop scheduler: per hop a guard interval with the
// generator held in reset, then a dwell of DWELL_N accepted samples.
module mtx_hop_scheduler
  import mtx_hop_pkg::*;
#(
  parameter int                     PHASE_WIDTH  = 24,
  parameter int                     NHOP_WIDTH   = 8,
  parameter int                     CNT_WIDTH    = 24,
  parameter int                     NUM_HOPS     = 64,
  parameter int                     DWELL_N      = 16384,
  parameter int                     GUARD_N      = 256,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = -24'd4194304,
  parameter logic [PHASE_WIDTH-1:0] HOP_DPH_INC  = 24'd131072
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   ext_trig,
  input  logic [NHOP_WIDTH-1:0]  hop_stride,
  input  logic                   gen_tready,
  output logic [PHASE_WIDTH-1:0] ph_inc,
  output logic                   gen_srst,
  output logic                   tx_active,
  output logic [NHOP_WIDTH-1:0]  hop_idx,
  output logic                   hop_done,
  output logic                   frame_done,
  output logic [1:0]             sched_state
);

  localparam logic [NHOP_WIDTH-1:0] IDX_MASK = NHOP_WIDTH'(NUM_HOPS - 1);
  localparam logic [NHOP_WIDTH-1:0] LAST_HOP = NHOP_WIDTH'(NUM_HOPS - 1);

  sched_state_t          state, state_nx;
  logic                  trig_q;
  logic [NHOP_WIDTH-1:0] stride, acc, acc_nx, hop_cnt, idx_nx;
  logic                  trig_rise, dwell_last, last_hop;
  logic                  frame_start, hop_adv;
  logic                  cnt_load, cnt_en, cnt_tc;
  logic [CNT_WIDTH-1:0]  cnt_load_val;
  logic [PHASE_WIDTH-1:0] ph_nx;

  assign trig_rise  = ext_trig & ~trig_q;
  assign dwell_last = (state == ST_DWELL) && gen_tready && cnt_tc;
  assign last_hop   = (hop_cnt == LAST_HOP);

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_nx = ST_WAIT_TRIG;
        ST_WAIT_TRIG: if (trig_rise) state_nx = ST_GUARD;
        ST_GUARD:     if (cnt_tc) state_nx = ST_DWELL;
        ST_DWELL:     if (dwell_last) state_nx = last_hop ? ST_WAIT_TRIG : ST_GUARD;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  assign frame_start = (state == ST_WAIT_TRIG) && enable && trig_rise;
  assign hop_adv     = enable && dwell_last && !last_hop;
  assign acc_nx      = frame_start ? '0 : (hop_adv ? acc + stride : acc);
  assign idx_nx      = acc_nx & IDX_MASK;
  assign ph_nx       = PHASE_WIDTH'(mtx_hop_ph_inc(32'(START_PH_INC), 32'(HOP_DPH_INC),
                                                   32'(idx_nx)));

  // One shared counter, reloaded on every state change; guard ignores tready.
  assign cnt_load     = (state_nx != state);
  assign cnt_load_val = (state_nx == ST_GUARD) ? CNT_WIDTH'(GUARD_N - 1)
                                               : CNT_WIDTH'(DWELL_N - 1);
  assign cnt_en       = (state == ST_GUARD) || ((state == ST_DWELL) && gen_tready);

  mtx_cycle_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      trig_q     <= 1'b0;
      stride     <= '0;
      acc        <= '0;
      hop_cnt    <= '0;
      ph_inc     <= START_PH_INC;
      hop_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state  <= state_nx;
      trig_q <= ext_trig;
      acc    <= acc_nx;
      if (frame_start) begin
        stride  <= hop_stride | NHOP_WIDTH'(1);
        hop_cnt <= '0;
      end else if (hop_adv) begin
        hop_cnt <= hop_cnt + NHOP_WIDTH'(1);
      end
      // Increment is presented from the first guard cycle of each hop.
      if (state_nx == ST_GUARD && state != ST_GUARD) ph_inc <= ph_nx;
      hop_done   <= enable && dwell_last;
      frame_done <= enable && dwell_last && last_hop;
    end
  end

  assign hop_idx     = acc & IDX_MASK;
  assign gen_srst    = (state != ST_DWELL);
  assign tx_active   = (state == ST_DWELL);
  assign sched_state = state;

endmodule
